spi_motor_rx: RTL and testbench

SPI_MOTOR_RX -- requirements
Module: spi_motor_rx

---
 rtl/spi_motor_rx.sv | 170 +++++++++++++++++
 tb/tb_spi_motor_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_motor_rx.sv
// spi_motor_rx: SPI slave that receives NUM_CH motor commands of WIDTH bits
// per frame, commits them on a correctly sized frame and echoes the last
// committed frame on sdo.
// Optional watchdog compiled in with macro SPI_MOTOR_RX_WDOG_EN.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_IDLE | after reset; wait for cs_n high so a frame cut by reset is dropped
// IDLE      | bus idle, waiting for a cs_n falling edge
// SHIFT     | frame in progress, capturing sdi on sck rise, driving sdo
module spi_motor_rx #(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sck,
  input  logic                      cs_n,
  input  logic                      sdi,
  output logic                      sdo,
  output logic [NUM_CH*WIDTH-1:0]   motor,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      timeout
);

  localparam int TOTAL = NUM_CH * WIDTH;
  localparam int CW    = $clog2(TOTAL + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(TOTAL);
  localparam logic [CW-1:0] CNT_OVR  = CW'(TOTAL + 1);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  state_t state, state_nxt;

  // stages [0],[1] synchronize; stage [2] is the edge-detect reference
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] sdi_q;

  logic [CW-1:0]    bit_cnt;
  logic [TOTAL-1:0] rx_sr;
  logic [TOTAL-1:0] tx_sr;

  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic start, finish, commit, reject;
  logic wd_expire;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];

  // input synchronizers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_q <= '0;
      cs_q  <= '0;
      sdi_q <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck};
      cs_q  <= {cs_q[1:0], cs_n};
      sdi_q <= {sdi_q[0], sdi};
    end
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= WAIT_IDLE;
    else          state <= state_nxt;
  end

  // next-state and frame start/finish strobes
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      WAIT_IDLE: if (cs_q[1]) state_nxt = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  assign commit = finish && (bit_cnt == CNT_FULL);
  assign reject = finish && (bit_cnt != CNT_FULL);

  // receive shift register and saturating bit counter; overrun bits are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else if (start) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
    end else if (state == SHIFT && sck_rise) begin
      if (bit_cnt < CNT_FULL) begin
        rx_sr   <= {rx_sr[TOTAL-2:0], sdi_q[1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= CNT_OVR;
      end
    end
  end

  // transmit copy of motor, zero-filled so sdo reads 0 once exhausted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sr <= '0;
    end else if (start) begin
      tx_sr <= motor;
    end else if (state == SHIFT && sck_fall) begin
      tx_sr <= {tx_sr[TOTAL-2:0], 1'b0};
    end
  end

  assign sdo = (state == SHIFT) & tx_sr[TOTAL-1];

  // output register: commit, reject and watchdog clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      motor     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= commit;
      frame_err <= reject;
      if (commit)         motor <= rx_sr;
      else if (wd_expire) motor <= '0;
    end
  end

`ifdef SPI_MOTOR_RX_WDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

  logic [WDW-1:0] wd_cnt;

  // watchdog: counts clocks since last commit, saturating at TIMEOUT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              wd_cnt <= '0;
    else if (commit)           wd_cnt <= '0;
    else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
  end

  // motor is cleared on the same edge the counter reaches TIMEOUT
  assign wd_expire = !commit && (wd_cnt == WD_MAX - 1'b1);
  assign timeout   = (wd_cnt == WD_MAX);
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_motor_rx.sv
// Testbench for spi_motor_rx: randomized SPI frames against a frame-level
// reference model (last committed word plus commit time for the watchdog).
module tb_spi_motor_rx;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 8;
  localparam int TOTAL  = NUM_CH * WIDTH;
  localparam int TMO    = 100;
`ifdef SPI_MOTOR_RX_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0;
  logic cs_n = 1'b1;
  logic sdi = 1'b0;
  logic sdo, valid, frame_err, timeout;
  logic [TOTAL-1:0] motor;

  spi_motor_rx #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .sck(sck), .cs_n(cs_n), .sdi(sdi),
    .sdo(sdo), .motor(motor), .valid(valid), .frame_err(frame_err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // reference model: last committed word and the clock edge it committed on
  logic [TOTAL-1:0] m_motor;
  int unsigned      m_commit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [TOTAL-1:0] motor_at(input int unsigned c);
    if (WDOG && (c - m_commit) >= TMO) return '0;
    return m_motor;
  endfunction

  function automatic logic timeout_at(input int unsigned c);
    return WDOG && ((c - m_commit) >= TMO);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_motor  = '0;
    m_commit = cyc;
  endtask

  // clock nbits out MSB first; sdo sampled at each sck rise against tx
  task automatic shift_bits(input logic [31:0] data, input int nbits,
                            input bit chk_sdo, input logic [TOTAL-1:0] tx);
    for (int i = 0; i < nbits; i++) begin
      sdi = data[nbits-1-i];
      tick(4);
      sck = 1'b1;
      if (chk_sdo) begin
        if (i < TOTAL) check($sformatf("sdo_bit%0d", i), 32'(sdo), 32'(tx[TOTAL-1-i]));
        else           check($sformatf("sdo_bit%0d", i), 32'(sdo), 32'd0);
      end
      tick(4);
      sck = 1'b0;
    end
  endtask

  // raise cs_n and check the commit/reject pulses and their latency
  task automatic end_frame(input bit ok, input bit err, input logic [TOTAL-1:0] data);
    int unsigned x;
    int nv, nf, vat, fat;
    tick(4);
    cs_n = 1'b1;
    x = cyc;
    nv = 0; nf = 0; vat = 0; fat = 0;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      if (valid)     begin nv++; vat = k; end
      if (frame_err) begin nf++; fat = k; end
    end
    if (ok) begin
      m_motor  = data;
      m_commit = x + 3;
    end
    check("valid_count", 32'(nv), ok ? 32'd1 : 32'd0);
    check("valid_latency", 32'(vat), ok ? 32'd3 : 32'd0);
    check("ferr_count", 32'(nf), err ? 32'd1 : 32'd0);
    check("ferr_latency", 32'(fat), err ? 32'd3 : 32'd0);
    check("motor", 32'(motor), 32'(motor_at(cyc)));
    check("timeout", 32'(timeout), 32'(timeout_at(cyc)));
    check("sdo_idle", 32'(sdo), 32'd0);
    tick(4);
  endtask

  task automatic send_frame(input logic [31:0] data, input int nbits, input bit chk_sdo);
    logic [TOTAL-1:0] tx;
    int unsigned e;
    cs_n = 1'b0;
    e = cyc;
    tx = motor_at(e + 2);
    tick(4);
    shift_bits(data, nbits, chk_sdo, tx);
    end_frame(nbits == TOTAL, nbits != TOTAL, data[TOTAL-1:0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int nb;
    int lens [5] = '{0, 1, 15, 17, 20};

    reset_n = 1'b0;
    tick(3);
    check("rst_motor", 32'(motor), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    reset_n = 1'b1;
    model_reset();
    tick(4);

    send_frame(32'hA53C, 16, 1'b1);

    send_frame(32'h1234, 16, 1'b1);
    send_frame(32'h1234 >> 1, 15, 1'b1);
    send_frame(32'h1234 << 1 | 1, 17, 1'b1);
    send_frame(32'h0, 0, 1'b0);

    send_frame(32'hBEEF, 16, 1'b1);
    send_frame($urandom, 16, 1'b1);

    // frame in progress at reset release is ignored
    reset_n = 1'b0;
    cs_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    model_reset();
    tick(4);
    shift_bits($urandom, 16, 1'b0, '0);
    end_frame(1'b0, 1'b0, '0);

    // reset mid-frame
    send_frame(32'hCAFE, 16, 1'b0);
    cs_n = 1'b0;
    tick(4);
    shift_bits(32'h1FF, 9, 1'b0, '0);
    reset_n = 1'b0;
    tick(1);
    check("midrst_motor", 32'(motor), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_ferr", 32'(frame_err), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    check("midrst_sdo", 32'(sdo), 32'd0);
    reset_n = 1'b1;
    model_reset();
    tick(2);
    end_frame(1'b0, 1'b0, '0);
    send_frame(32'h00FF, 16, 1'b1);

    // randomized frames, mostly well-formed
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 9) < 6) nb = 16;
      else nb = lens[$urandom_range(0, 4)];
      send_frame($urandom, nb, 1'b1);
    end

    // watchdog boundary
    send_frame(32'h7F7F, 16, 1'b1);
    while (cyc < m_commit + TMO - 1) tick(1);
    check("wd_before_timeout", 32'(timeout), 32'(timeout_at(cyc)));
    check("wd_before_motor", 32'(motor), 32'(motor_at(cyc)));
    tick(1);
    check("wd_at_timeout", 32'(timeout), WDOG ? 32'd1 : 32'd0);
    check("wd_at_motor", 32'(motor), WDOG ? 32'd0 : 32'h7F7F);
    tick(150);
    check("wd_hold_timeout", 32'(timeout), 32'(timeout_at(cyc)));
    check("wd_hold_motor", 32'(motor), 32'(motor_at(cyc)));
    send_frame(32'h1111, 16, 1'b1);
    check("wd_recover_timeout", 32'(timeout), 32'd0);
    check("wd_recover_motor", 32'(motor), 32'h1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
